// File: rtl/res_ctl_pkg.sv
// Shared types and constants for the reset controller: FSM states, reset-cause
// encodings and the saturating counter helper.
package res_ctl_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'b00,
    S_BTN  = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // Reset count sticks at its maximum instead of wrapping to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    logic [7:0] result;
    if (value == COUNT_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/res_ctl_btn_debounce.sv
// Reset pushbutton conditioning: multi-flop synchronizer followed by a
// restart-on-bounce debouncer that emits a one-cycle pulse per accepted press.
module btn_debounce
  import res_ctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 256
) (
  input  logic clk_cog,
  input  logic nres,
  input  logic din_n,
  output logic dout_n,
  output logic press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [DW-1:0]          cnt_r;
  logic                   sync_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // The accepted level only follows the synchronized level after it has
  // disagreed for DEB_CYCLES edges in a row; any agreement restarts the wait.
  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      cnt_r  <= {DW{1'b0}};
      dout_n <= 1'b1;
      press  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din_n};
      press  <= 1'b0;
      if (sync_s == dout_n) begin
        cnt_r <= {DW{1'b0}};
      end else if (cnt_r == DEB_LAST) begin
        cnt_r  <= {DW{1'b0}};
        dout_n <= sync_s;
        press  <= ~sync_s;
      end else begin
        cnt_r <= cnt_r + DW'(1);
      end
    end
  end

endmodule

// File: rtl/res_ctl.sv
// Reset controller: merges power-on, debounced pushbutton and software reset
// requests into one stretched, registered core reset plus cause/count status.
module res_ctl
  import res_ctl_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int DEB_CYCLES  = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_cog,
  input  logic       nres,
  input  logic       btn_n,
  input  logic       cfg_rst,
  output logic       inp_res,
  output logic       res_led,
  output logic [1:0] res_cause,
  output logic [7:0] res_count
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("res_ctl: HOLD_CYCLES must be at least 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("res_ctl: DEB_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("res_ctl: SYNC_STAGES must be at least 2");
  end

  state_t        state_r;
  logic [HW-1:0] hold_cnt_r;
  logic          por_pend_r;
  logic          cfg_prev_r;
  logic          btn_level_s;
  logic          press_s;
  logic          soft_req_s;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_btn_debounce (
    .clk_cog (clk_cog),
    .nres    (nres),
    .din_n   (btn_n),
    .dout_n  (btn_level_s),
    .press   (press_s)
  );

  // cfg_prev_r is forced low outside RUN, so a request already high when RUN
  // is entered looks like a fresh rising edge.
  assign soft_req_s = cfg_rst & ~cfg_prev_r;

  // Reset sequencing FSM with registered reset, LED, cause and count outputs.
  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      state_r    <= S_HOLD;
      hold_cnt_r <= {HW{1'b0}};
      por_pend_r <= 1'b1;
      cfg_prev_r <= 1'b0;
      inp_res    <= 1'b1;
      res_led    <= 1'b1;
      res_cause  <= CAUSE_POR;
      res_count  <= 8'd0;
    end else begin
      // The first edge after power-on release is the hold entry, not a count.
      por_pend_r <= 1'b0;
      cfg_prev_r <= (state_r == S_RUN) ? cfg_rst : 1'b0;
      case (state_r)
        S_HOLD: begin
          inp_res <= 1'b1;
          res_led <= 1'b1;
          if (press_s) begin
            state_r <= S_BTN;
          end else if (por_pend_r) begin
            hold_cnt_r <= {HW{1'b0}};
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_r <= S_RUN;
            inp_res <= 1'b0;
            res_led <= ~btn_level_s;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        S_BTN: begin
          inp_res <= 1'b1;
          res_led <= 1'b1;
          if (btn_level_s) begin
            state_r    <= S_HOLD;
            hold_cnt_r <= {HW{1'b0}};
          end else begin
            state_r <= S_BTN;
          end
        end
        S_RUN: begin
          // A press beats a simultaneous software request.
          if (press_s) begin
            state_r   <= S_BTN;
            inp_res   <= 1'b1;
            res_led   <= 1'b1;
            res_cause <= CAUSE_BTN;
            res_count <= sat_inc(res_count);
          end else if (soft_req_s) begin
            state_r    <= S_HOLD;
            hold_cnt_r <= {HW{1'b0}};
            inp_res    <= 1'b1;
            res_led    <= 1'b1;
            res_cause  <= CAUSE_SOFT;
            res_count  <= sat_inc(res_count);
          end else begin
            inp_res <= 1'b0;
            res_led <= ~btn_level_s;
          end
        end
        default: begin
          state_r    <= S_HOLD;
          hold_cnt_r <= {HW{1'b0}};
          inp_res    <= 1'b1;
          res_led    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_res_ctl.sv
// Self-checking bench for res_ctl: cycle-exact vector table through an
// expected-value queue, plus latency measurements for the button path.
module tb_res_ctl;
  import res_ctl_pkg::*;

  localparam int HOLD = 8;
  localparam int DEB  = 4;
  localparam int SYNC = 2;

  typedef struct {
    logic       nres;
    logic       btn_n;
    logic       cfg_rst;
    logic       inp_res;
    logic       res_led;
    logic [1:0] res_cause;
    logic [7:0] res_count;
  } vec_t;

  logic       clk_cog = 1'b0;
  logic       nres    = 1'b0;
  logic       btn_n   = 1'b1;
  logic       cfg_rst = 1'b0;
  logic       inp_res;
  logic       res_led;
  logic [1:0] res_cause;
  logic [7:0] res_count;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  res_ctl #(
    .HOLD_CYCLES (HOLD),
    .DEB_CYCLES  (DEB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_cog   (clk_cog),
    .nres      (nres),
    .btn_n     (btn_n),
    .cfg_rst   (cfg_rst),
    .inp_res   (inp_res),
    .res_led   (res_led),
    .res_cause (res_cause),
    .res_count (res_count)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic add(input int n, input logic nr, input logic b, input logic c,
                     input logic ei, input logic el, input logic [1:0] ec,
                     input logic [7:0] en);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.nres = nr; v.btn_n = b; v.cfg_rst = c;
      v.inp_res = ei; v.res_led = el; v.res_cause = ec; v.res_count = en;
      tbl.push_back(v);
    end
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    vec_t e;
    int   lat;
    logic [7:0] c;

    // Power-on: 3 reset edges, then exactly HOLD high samples from the first released edge.
    add(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_POR, 8'd0);
    add(8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_POR, 8'd0);
    add(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_POR, 8'd0);
    // Bouncy button: 20 cycles toggling every 2, no reset; then final fall.
    for (int p = 0; p < 5; p++) begin
      add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CAUSE_POR, 8'd0);
      add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_POR, 8'd0);
    end
    add(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CAUSE_POR, 8'd0);
    add(6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CAUSE_BTN, 8'd1);
    add(14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_BTN, 8'd1);
    add(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_BTN, 8'd1);
    // Single-cycle software reset.
    add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CAUSE_SOFT, 8'd2);
    add(7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_SOFT, 8'd2);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_SOFT, 8'd2);
    // cfg_rst held high: ignored during hold, retriggers at RUN entry.
    add(8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CAUSE_SOFT, 8'd3);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CAUSE_SOFT, 8'd3);
    add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CAUSE_SOFT, 8'd4);
    add(7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_SOFT, 8'd4);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_SOFT, 8'd4);
    // Press and cfg_rst in the same RUN cycle: button wins, one increment.
    add(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CAUSE_SOFT, 8'd4);
    add(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, CAUSE_BTN, 8'd5);
    add(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CAUSE_BTN, 8'd5);
    add(14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_BTN, 8'd5);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_BTN, 8'd5);
    // nres pulse in the middle of a button-initiated hold.
    add(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CAUSE_BTN, 8'd5);
    add(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CAUSE_BTN, 8'd6);
    add(8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_BTN, 8'd6);
    add(1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_POR, 8'd0);
    add(8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_POR, 8'd0);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_POR, 8'd0);
    // Saturation: 260 back-to-back software resets.
    for (int i = 1; i <= 260; i++) begin
      c = (i > 255) ? 8'd255 : 8'(i);
      add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CAUSE_SOFT, c);
      add(7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CAUSE_SOFT, c);
      add(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CAUSE_SOFT, c);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_cog);
      nres    = tbl[i].nres;
      btn_n   = tbl[i].btn_n;
      cfg_rst = tbl[i].cfg_rst;
      exp_q.push_back(tbl[i]);
      @(posedge clk_cog);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({inp_res, res_led, res_cause, res_count} !==
          {e.inp_res, e.res_led, e.res_cause, e.res_count}) begin
        n_errors++;
        $display("FAIL vec[%0d]: got inp_res=%b res_led=%b res_cause=%b res_count=%0d, expected %b %b %b %0d",
                 i, inp_res, res_led, res_cause, res_count,
                 e.inp_res, e.res_led, e.res_cause, e.res_count);
      end
    end

    // Button latency from a saturated RUN state.
    @(negedge clk_cog);
    btn_n = 1'b0;
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk_cog);
      #1;
      if (inp_res === 1'b1) begin
        lat = k;
        break;
      end
    end
    check_val("press_latency", lat, SYNC + DEB + 1);
    check_val("press_cause", int'(res_cause), int'(CAUSE_BTN));
    check_val("press_count_sat", int'(res_count), 255);

    @(negedge clk_cog);
    btn_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_cog);
      #1;
      if (inp_res === 1'b0) begin
        lat = k - 1;
        break;
      end
    end
    check_val("release_high_cycles", lat, SYNC + DEB + HOLD);
    check_val("release_led", int'(res_led), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
